// File: rtl/pc_call_stack.sv
// Fetch-stage program counter with load, increment, relative branch and a
// return-address stack for call/return. Overflow/underflow are sticky.
module pc_call_stack #(
    parameter int             N         = 8,
    parameter int             DEPTH     = 4,
    parameter logic [N-1:0]   RESET_VEC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N-1:0]                 pc_data,
    input  logic [N-1:0]                 offset,
    input  logic                         pc_load,
    input  logic                         pc_inc,
    input  logic                         pc_branch,
    input  logic                         call,
    input  logic                         ret,
    output logic [N-1:0]                 pc_out,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         ovf_err,
    output logic                         unf_err
);

    localparam int              DW      = $clog2(DEPTH + 1);
    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0]   DEPTH_W = DW'(DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CALL,
        OP_RET,
        OP_LOAD,
        OP_BRANCH,
        OP_INC
    } op_e;

    op_e            op;
    logic [N-1:0]   stack [DEPTH];
    logic [N-1:0]   pc_nxt;
    logic [N-1:0]   pc_plus1;
    logic [DW-1:0]  depth_nxt;
    logic [AW-1:0]  push_idx;
    logic [AW-1:0]  top_idx;
    logic           push;
    logic           ovf_set;
    logic           unf_set;

    // The depth counter doubles as the stack pointer: next free slot / top entry.
    assign pc_plus1 = pc_out + N'(1);
    assign push_idx = AW'(depth);
    assign top_idx  = AW'(depth - 1'b1);

    // Only the highest-priority asserted control acts in a given cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        op = OP_HOLD;
        if (call)           op = OP_CALL;
        else if (ret)       op = OP_RET;
        else if (pc_load)   op = OP_LOAD;
        else if (pc_branch) op = OP_BRANCH;
        else if (pc_inc)    op = OP_INC;
    end

    always_comb begin
        pc_nxt    = pc_out;
        depth_nxt = depth;
        push      = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case (op)
            OP_CALL: begin
                if (!stack_full) begin
                    push      = 1'b1;
                    depth_nxt = depth + 1'b1;
                    pc_nxt    = pc_data;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            OP_RET: begin
                if (!stack_empty) begin
                    depth_nxt = depth - 1'b1;
                    pc_nxt    = stack[top_idx];
                end else begin
                    unf_set = 1'b1;
                end
            end
            OP_LOAD:   pc_nxt = pc_data;
            // Same-width add: sign extension at N bits is implicit and wrap is silent.
            OP_BRANCH: pc_nxt = pc_out + offset;
            OP_INC:    pc_nxt = pc_plus1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            pc_out      <= RESET_VEC;
            depth       <= '0;
            stack_full  <= 1'b0;
            stack_empty <= 1'b1;
            ovf_err     <= 1'b0;
            unf_err     <= 1'b0;
        end else begin
            pc_out      <= pc_nxt;
            depth       <= depth_nxt;
            stack_full  <= (depth_nxt == DEPTH_W);
            stack_empty <= (depth_nxt == '0);
            ovf_err     <= ovf_err | ovf_set;
            unf_err     <= unf_err | unf_set;
        end
    end

    // NOTE: entry storage is deliberately not reset; depth alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            stack[push_idx] <= pc_plus1;
        end
    end

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack: a reference model pushes expected
// state into a scoreboard queue each cycle, popped and compared after the edge.
module tb_pc_call_stack;

    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] pc_data;
    logic [N-1:0] offset;
    logic         pc_load;
    logic         pc_inc;
    logic         pc_branch;
    logic         call;
    logic         ret;
    logic [N-1:0] pc_out;
    logic [2:0]   depth;
    logic         stack_full;
    logic         stack_empty;
    logic         ovf_err;
    logic         unf_err;

    pc_call_stack #(.N(N), .DEPTH(DEPTH), .RESET_VEC(8'h10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_data    (pc_data),
        .offset     (offset),
        .pc_load    (pc_load),
        .pc_inc     (pc_inc),
        .pc_branch  (pc_branch),
        .call       (call),
        .ret        (ret),
        .pc_out     (pc_out),
        .depth      (depth),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] pc;
        int           dep;
        logic         full;
        logic         empty;
        logic         ovf;
        logic         unf;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_step = 0;

    // Reference model state
    logic [N-1:0] m_pc;
    int           m_depth;
    logic [N-1:0] m_stk [DEPTH];
    logic         m_ovf;
    logic         m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, predict, then compare after posedge.
    task automatic step(input logic r, input logic ld, input logic inc, input logic br,
                        input logic cl, input logic rt,
                        input logic [N-1:0] d, input logic [N-1:0] off);
        exp_t e;
        exp_t o;
        @(negedge clk);
        rst_n = r; pc_load = ld; pc_inc = inc; pc_branch = br;
        call = cl; ret = rt; pc_data = d; offset = off;
        if (!r) begin
            m_pc = 8'h10; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (cl) begin
            if (m_depth < DEPTH) begin
                m_stk[m_depth] = m_pc + 8'd1;
                m_depth++;
                m_pc = d;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (rt) begin
            if (m_depth > 0) begin
                m_depth--;
                m_pc = m_stk[m_depth];
            end else begin
                m_unf = 1'b1;
            end
        end else if (ld) begin
            m_pc = d;
        end else if (br) begin
            m_pc = m_pc + off;
        end else if (inc) begin
            m_pc = m_pc + 8'd1;
        end
        e.pc = m_pc; e.dep = m_depth; e.full = (m_depth == DEPTH);
        e.empty = (m_depth == 0); e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_step++;
        o = sb.pop_front();
        check($sformatf("s%0d.pc", n_step),    pc_out,      o.pc);
        check($sformatf("s%0d.depth", n_step), depth,       o.dep);
        check($sformatf("s%0d.full", n_step),  stack_full,  o.full);
        check($sformatf("s%0d.empty", n_step), stack_empty, o.empty);
        check($sformatf("s%0d.ovf", n_step),   ovf_err,     o.ovf);
        check($sformatf("s%0d.unf", n_step),   unf_err,     o.unf);
    endtask

    // Short helpers: step(rst_n, load, inc, branch, call, ret, data, offset)
    task automatic do_hold();                   step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00); endtask
    task automatic do_load(input logic [7:0] d); step(1, 1, 0, 0, 0, 0, d, 8'h00);     endtask
    task automatic do_inc();                    step(1, 0, 1, 0, 0, 0, 8'h00, 8'h00); endtask
    task automatic do_call(input logic [7:0] d); step(1, 0, 0, 0, 1, 0, d, 8'h00);     endtask
    task automatic do_ret();                    step(1, 0, 0, 0, 0, 1, 8'h00, 8'h00); endtask
    task automatic do_rst();                    step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00); endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; pc_load = 1'b0; pc_inc = 1'b0; pc_branch = 1'b0;
        call = 1'b0; ret = 1'b0; pc_data = '0; offset = '0;
        m_pc = 8'h10; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;

        // 1. Reset held two edges with pc_inc asserted, then release
        do_rst();
        do_rst();
        check("t1.reset_pc", pc_out, 8'h10);
        check("t1.reset_empty", stack_empty, 1'b1);
        do_inc();
        check("t1.first_inc", pc_out, 8'h11);

        // 2. Load / increment / branch priority
        do_load(8'h31);
        do_inc();
        do_inc();
        check("t2.inc2", pc_out, 8'h33);
        step(1, 0, 0, 1, 0, 0, 8'h00, 8'hFE);
        check("t2.branch_back", pc_out, 8'h31);
        step(1, 0, 1, 1, 0, 0, 8'h00, 8'h05);
        check("t2.branch_wins", pc_out, 8'h36);
        repeat (3) do_hold();
        check("t2.hold", pc_out, 8'h36);

        // 3. Nested call / return
        do_load(8'h20);
        do_call(8'h40);
        do_inc();
        do_call(8'h80);
        check("t3.depth2", depth, 3'd2);
        do_ret();
        check("t3.ret_inner", pc_out, 8'h42);
        do_ret();
        check("t3.ret_outer", pc_out, 8'h21);

        // 4. Overflow: fill, attempt a fifth call, drain in reverse order
        do_call(8'h50);
        do_call(8'h60);
        do_call(8'h70);
        do_call(8'h80);
        check("t4.full", stack_full, 1'b1);
        do_call(8'hAA);
        check("t4.ovf_pc_hold", pc_out, 8'h80);
        check("t4.ovf_flag", ovf_err, 1'b1);
        do_ret(); check("t4.pop1", pc_out, 8'h71);
        do_ret(); check("t4.pop2", pc_out, 8'h61);
        do_ret(); check("t4.pop3", pc_out, 8'h51);
        do_ret(); check("t4.pop4", pc_out, 8'h22);
        check("t4.ovf_sticky", ovf_err, 1'b1);

        // 5. Underflow; call+ret together after a clean reset raises no error
        do_ret();
        check("t5.unf_pc_hold", pc_out, 8'h22);
        check("t5.unf_flag", unf_err, 1'b1);
        do_rst();
        step(1, 0, 0, 0, 1, 1, 8'h90, 8'h00);
        check("t5.callret_pc", pc_out, 8'h90);
        check("t5.callret_no_unf", unf_err, 1'b0);
        do_ret();
        do_ret();
        check("t5.unf_again", unf_err, 1'b1);

        // 6. Wrap-around and reset with a partially filled stack
        do_load(8'hFF);
        do_inc();
        check("t6.inc_wrap", pc_out, 8'h00);
        do_load(8'hFF);
        do_call(8'h10);
        do_ret();
        check("t6.push_wrap", pc_out, 8'h00);
        do_call(8'h01);
        do_call(8'h02);
        do_call(8'h03);
        check("t6.depth3", depth, 3'd3);
        do_rst();
        check("t6.rst_depth", depth, 3'd0);
        check("t6.rst_unf", unf_err, 1'b0);
        do_ret();
        check("t6.ret_after_rst", unf_err, 1'b1);

        // Random mixed traffic against the model
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 8'($urandom), 8'($urandom));
        end

        check("sb.drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
